branch_redirect_unit: RTL

//  Consumer of the EX-stage branch decision. Predicts SB-type branches at fetch from a table of
//  2-bit saturating counters (BHT) and computes the predicted target. At EX it compares the

---
 rtl/riscv_pkg.sv | 31 +++
 rtl/branch_redirect_unit_if.sv | 38 +++
 rtl/branch_redirect_unit_bht.sv | 41 ++++
 rtl/branch_redirect_unit.sv | 87 ++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V branch decode helpers: SB-type opcode/funct3 constants, branch
// classification, B-immediate extraction and the redirect FSM state type.
package riscv_pkg;

  localparam logic [6:0] SB_TYPE_OP = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fsm_t;

  function automatic logic is_branch(input logic [31:0] instr);
    logic [2:0] f3;
    f3 = instr[14:12];
    return (instr[6:0] == SB_TYPE_OP) &&
           ((f3 == F3_BEQ)  || (f3 == F3_BNE)  || (f3 == F3_BLT) ||
            (f3 == F3_BGE)  || (f3 == F3_BLTU) || (f3 == F3_BGEU));
  endfunction

  function automatic logic signed [31:0] b_imm(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/branch_redirect_unit_if.sv
// Fetch/EX/redirect bundle between the pipeline and the branch redirect unit.
interface branch_redirect_unit_if #(
  parameter int CNT_W = 16
) ();
  logic              if_valid;
  logic [31:0]       if_pc;
  logic [31:0]       if_instr;
  logic              pred_taken;
  logic [31:0]       pred_target;

  logic              ex_valid;
  logic              ex_stall;
  logic [31:0]       ex_pc;
  logic [31:0]       ex_instr;
  logic              ex_branch;
  logic              ex_pred_taken;

  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic [CNT_W-1:0]  branch_cnt;
  logic [CNT_W-1:0]  mispred_cnt;

  modport master (
    output if_valid, if_pc, if_instr,
    output ex_valid, ex_stall, ex_pc, ex_instr, ex_branch, ex_pred_taken,
    input  pred_taken, pred_target,
    input  redirect, redirect_pc, flush_if_id, flush_id_ex, branch_cnt, mispred_cnt
  );

  modport slave (
    input  if_valid, if_pc, if_instr,
    input  ex_valid, ex_stall, ex_pc, ex_instr, ex_branch, ex_pred_taken,
    output pred_taken, pred_target,
    output redirect, redirect_pc, flush_if_id, flush_id_ex, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_redirect_unit_bht.sv
// Branch history table: 2-bit saturating counters, asynchronous read port and a
// single train port. Entries come out of reset weakly not-taken.
module branch_history_table #(
  parameter int BHT_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BHT_IDX_W-1:0] i_rd_idx,
  output logic                 o_rd_taken,
  input  logic                 i_upd_en,
  input  logic [BHT_IDX_W-1:0] i_upd_idx,
  input  logic                 i_upd_taken
);
  localparam int ENTRIES = 1 << BHT_IDX_W;

  logic [1:0] r_cnt [ENTRIES];
  logic [1:0] w_cur;
  logic [1:0] w_cnt_nxt;

  // Read is combinational from the register array, so a same-cycle update is not visible yet.
  assign o_rd_taken = r_cnt[i_rd_idx][1];
  assign w_cur      = r_cnt[i_upd_idx];

  always_comb begin
    w_cnt_nxt = w_cur;
    if (i_upd_taken) begin
      if (w_cur != 2'b11) w_cnt_nxt = w_cur + 2'b01;
    end else begin
      if (w_cur != 2'b00) w_cnt_nxt = w_cur - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= 2'b01;
    end else if (i_upd_en) begin
      r_cnt[i_upd_idx] <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/branch_redirect_unit.sv
// Predicts SB-type branches at fetch and, on an EX-stage mispredict, issues a
// one-cycle registered redirect with IF/ID and ID/EX flushes.
module branch_redirect_unit
  import riscv_pkg::*;
#(
  parameter int BHT_IDX_W = 4,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  branch_redirect_unit_if.slave  bus
);

  fsm_t             r_state;
  fsm_t             w_state_nxt;
  logic             r_redirect;
  logic [31:0]      r_redirect_pc;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  logic             w_bht_taken;
  logic             w_resolve;
  logic             w_mispred;
  logic [31:0]      w_correct_pc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  branch_history_table #(
    .BHT_IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_idx    (bus.if_pc[BHT_IDX_W+1:2]),
    .o_rd_taken  (w_bht_taken),
    .i_upd_en    (w_resolve),
    .i_upd_idx   (bus.ex_pc[BHT_IDX_W+1:2]),
    .i_upd_taken (bus.ex_branch)
  );

  assign bus.pred_taken  = bus.if_valid & is_branch(bus.if_instr) & w_bht_taken;
  assign bus.pred_target = bus.if_pc + b_imm(bus.if_instr);

  // EX content during FLUSH is wrong-path and must not train or count.
  assign w_resolve    = bus.ex_valid & ~bus.ex_stall & is_branch(bus.ex_instr) & (r_state == RUN);
  assign w_mispred    = w_resolve & (bus.ex_branch != bus.ex_pred_taken);
  assign w_correct_pc = bus.ex_branch ? (bus.ex_pc + b_imm(bus.ex_instr)) : (bus.ex_pc + 32'd4);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_mispred) w_state_nxt = FLUSH;
      FLUSH:   w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      r_redirect <= w_mispred;
      if (w_mispred) begin
        r_redirect_pc <= w_correct_pc;
        r_mispred_cnt <= sat_inc(r_mispred_cnt);
      end
      if (w_resolve) r_branch_cnt <= sat_inc(r_branch_cnt);
    end
  end

  assign bus.redirect    = r_redirect;
  assign bus.flush_if_id = r_redirect;
  assign bus.flush_id_ex = r_redirect;
  assign bus.redirect_pc = r_redirect_pc;
  assign bus.branch_cnt  = r_branch_cnt;
  assign bus.mispred_cnt = r_mispred_cnt;

endmodule
